// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and nibble width.
package nsa_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Host-side handshake and result bus of the nibble-serial adder.
interface nsa_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/nibble_serial_adder_xor.sv
// Sum stage of one nibble: propagate terms XORed with the carries delivered by the CLB.
module nibble_sum_xor (
  input  logic [3:0] ina,
  input  logic [3:0] inb,
  input  logic       cin,
  input  logic       c1,
  input  logic       c2,
  input  logic       c3,
  output logic [3:0] s
);

  logic [3:0] p;

  assign p = ina ^ inb;
  assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// Sequential WIDTH-bit adder that feeds an external 4-bit CLB one nibble per clock
// and assembles sum, carry-out and signed overflow behind a start/busy/done handshake.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NIBS  = WIDTH / 4
) (
  input  logic       clk,
  input  logic       rst,
  nsa_if.slave       bus,
  output logic [3:0] clb_ina,
  output logic [3:0] clb_inb,
  output logic       clb_cin,
  input  logic       clb_c1,
  input  logic       clb_c2,
  input  logic       clb_c3,
  input  logic       clb_cout
);

  localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;
  logic [3:0]       nib_sum;

  assign clb_ina = a_sr[NIB_W-1:0];
  assign clb_inb = b_sr[NIB_W-1:0];
  assign clb_cin = carry;

  nibble_sum_xor u_sum_xor (
    .ina (clb_ina),
    .inb (clb_inb),
    .cin (clb_cin),
    .c1  (clb_c1),
    .c2  (clb_c2),
    .c3  (clb_c3),
    .s   (nib_sum)
  );

  // Operands shift right so the active nibble is always at bit 0 of the shift registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            carry  <= bus.cin;
            idx    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          sum_r[NIB_W*idx +: NIB_W] <= nib_sum;
          carry <= clb_cout;
          a_sr  <= a_sr >> NIB_W;
          b_sr  <= b_sr >> NIB_W;
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            cout_r <= clb_cout;
            ovf_r  <= clb_c3 ^ clb_cout;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: behavioural CLB plus an arithmetic reference model of the 16-bit add.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] clb_ina;
  logic [3:0] clb_inb;
  logic       clb_cin;
  logic       clb_c1;
  logic       clb_c2;
  logic       clb_c3;
  logic       clb_cout;
  logic [4:0] clb_full;

  int vectors = 0;
  int miscompares = 0;

  nsa_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .clb_ina  (clb_ina),
    .clb_inb  (clb_inb),
    .clb_cin  (clb_cin),
    .clb_c1   (clb_c1),
    .clb_c2   (clb_c2),
    .clb_c3   (clb_c3),
    .clb_cout (clb_cout)
  );

  always #25 clk = ~clk;

  // Carry into bit i recovered from the arithmetic nibble sum.
  assign clb_full = {1'b0, clb_ina} + {1'b0, clb_inb} + {4'b0, clb_cin};
  assign clb_c1   = clb_full[1] ^ clb_ina[1] ^ clb_inb[1];
  assign clb_c2   = clb_full[2] ^ clb_ina[2] ^ clb_inb[2];
  assign clb_c3   = clb_full[3] ^ clb_ina[3] ^ clb_inb[3];
  assign clb_cout = clb_full[4];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Issues one add and checks every cycle from the start edge through two cycles after done.
  // inject_k: cycle in which a stray start is driven; reset_k: cycle in which rst is driven.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic c,
                               input int inject_k, input int reset_k);
    logic [16:0] full;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
    logic        was_reset;
    full      = {1'b0, a} + {1'b0, b} + {16'b0, c};
    exp_sum   = full[15:0];
    exp_cout  = full[16];
    exp_ovf   = (a[15] == b[15]) && (exp_sum[15] != a[15]);
    was_reset = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = c;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (was_reset) begin
        checkOutput("busy_after_rst", {31'b0, bus.busy}, 32'd0);
        checkOutput("done_after_rst", {31'b0, bus.done}, 32'd0);
        checkOutput("sum_after_rst", {16'b0, bus.sum}, 32'd0);
        checkOutput("cout_after_rst", {31'b0, bus.cout}, 32'd0);
        checkOutput("ovf_after_rst", {31'b0, bus.ovf}, 32'd0);
      end else begin
        checkOutput($sformatf("busy_c%0d", k), {31'b0, bus.busy}, {31'b0, (k <= 4)});
        checkOutput($sformatf("done_c%0d", k), {31'b0, bus.done}, {31'b0, (k == 5)});
        if (k >= 5) begin
          checkOutput($sformatf("sum_c%0d", k), {16'b0, bus.sum}, {16'b0, exp_sum});
          checkOutput($sformatf("cout_c%0d", k), {31'b0, bus.cout}, {31'b0, exp_cout});
          checkOutput($sformatf("ovf_c%0d", k), {31'b0, bus.ovf}, {31'b0, exp_ovf});
        end
      end
      rst = (k == reset_k);
      if (k == reset_k) was_reset = 1'b1;
      if (k == inject_k) begin
        bus.start = 1'b1;
        bus.a     = 16'hAAAA;
        bus.b     = 16'h5555;
        bus.cin   = 1'b0;
      end else begin
        bus.start = 1'b0;
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("rst_done", {31'b0, bus.done}, 32'd0);
    checkOutput("rst_sum", {16'b0, bus.sum}, 32'd0);
    checkOutput("rst_cout", {31'b0, bus.cout}, 32'd0);
    checkOutput("rst_ovf", {31'b0, bus.ovf}, 32'd0);
    rst = 1'b0;

    applyStimulus(16'h1234, 16'h4321, 1'b0, 0, 0);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 0, 0);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 0, 0);
    applyStimulus(16'hFFFF, 16'h0000, 1'b1, 0, 0);
    applyStimulus(16'h8000, 16'h8000, 1'b0, 0, 0);
    applyStimulus(16'h00FF, 16'h0001, 1'b0, 2, 0);
    applyStimulus(16'h00FF, 16'h0001, 1'b0, 0, 3);
    applyStimulus(16'h0001, 16'h0001, 1'b0, 0, 0);

    for (int n = 0; n < 24; n++) begin
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 0, 0);
    end

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Sequential WIDTH-bit adder that sits directly around the 4-bit carry-lookahead block (CLB) and consumes its outputs. It processes one nibble per clock.
- Each cycle it drives the current operand nibbles and the running carry into the CLB. It takes back c1/c2/c3/cout, forms the four sum bits and registers the nibble carry for the next nibble.
- A start/busy/done handshake wraps the operation, and the final sum, carry-out and signed overflow are held until the next start.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and ≥ 4.
- NIBS, WIDTH/4, derived number of nibble steps; not overridden.

Ports:
- clk, input, 1, single system clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, request an add; sampled only in IDLE.
- a, input, WIDTH, operand A; captured on the accepted start.
- b, input, WIDTH, operand B; captured on the accepted start.
- cin, input, 1, carry-in; captured on the accepted start.
- busy, output, 1, high while in RUN.
- done, output, 1, one-cycle pulse in DONE.
- sum, output, WIDTH, registered result.
- cout, output, 1, registered final carry-out.
- ovf, output, 1, registered signed overflow.
- clb_ina, output, 4, current A nibble to CLB.
- clb_inb, output, 4, current B nibble to CLB.
- clb_cin, output, 1, running carry to CLB.
- clb_c1, input, 1, carry into bit 1 of the current nibble.
- clb_c2, input, 1, carry into bit 2 of the current nibble.
- clb_c3, input, 1, carry into bit 3 of the current nibble.
- clb_cout, input, 1, carry out of the current nibble.

Behaviour:
- Reset (rst=1 at an edge, in any state including mid-RUN):
  - state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0.
  - Operand shift registers, carry register and nibble index all cleared.
  - The operation in progress is abandoned with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at an edge:
  - a_sr<=a, b_sr<=b, carry<=cin, idx<=0.
  - sum<=0, cout<=0, ovf<=0; go to RUN.
- IDLE, start=0: stay in IDLE.
- CLB drive (combinational from registers, every state): clb_ina=a_sr[3:0], clb_inb=b_sr[3:0], clb_cin=carry. In IDLE/DONE these are don't-care but stable.
- Sum bits, with p_i = clb_ina[i] XOR clb_inb[i]:
  - s0 = p0 XOR clb_cin
  - s1 = p1 XOR clb_c1
  - s2 = p2 XOR clb_c2
  - s3 = p3 XOR clb_c3
- RUN, each edge:
  - sum[4*idx+3 : 4*idx] <= s.
  - carry <= clb_cout.
  - a_sr, b_sr shift right by 4 (zero fill).
  - idx <= idx+1.
- RUN, when idx == NIBS-1 at that edge:
  - cout <= clb_cout; ovf <= clb_c3 XOR clb_cout; go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then unconditionally IDLE.
- start is ignored in RUN and DONE; the request is not queued.
- Latency: accepted start edge + NIBS RUN edges; done is high in cycle NIBS+1 after the start edge. For WIDTH=16, done is high in the 5th cycle after the start edge.
- busy=1 exactly in the NIBS RUN cycles.
- sum, cout and ovf are stable from done until the next accepted start.
- Timing: the CLB path is 20 ns gate delay (xor 6 + and 7 + or 7). Minimum clk period is 40 ns; the bench uses 50 ns.
- Carry arithmetic is unsigned modulo 2^WIDTH; ovf is valid for two's-complement operands.

Decomposition:
- Shared package nsa_pkg:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - NIB_W=4.
- One natural sub-module, nibble_sum_xor: inputs ina[3:0], inb[3:0], cin, c1, c2, c3; output s[3:0]. Purely the p/sum XOR stage, instantiated once.
- The FSM, shift registers and result register live in nibble_serial_adder. The CLB is instantiated alongside it at the next level up, not inside.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0, start for 1 cycle -> busy high 4 cycles, done in the 5th cycle; sum=0x5555, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; carry ripples through all 4 nibbles.
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
- a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0.
- Start 0x00FF+0x0001 -> result 0x0100. A start pulse with 0xAAAA+0x5555 during its 2nd RUN cycle is ignored; a single done pulse follows with sum=0x0100.
- Assert rst for 1 cycle in the 3rd RUN cycle -> next cycle IDLE, busy=0, no done, sum=0. A following 0x0001+0x0001 yields 0x0002.
